elevator_dir_ctrl: RTL and testbench
====================================

ELEVATOR_DIR_CTRL -- requirements
Module: elevator_dir_ctrl

Interface
REQ-001 Parameter: NUM_ELEV, default 2, number of elevator cars.
REQ-002 Parameter: NUM_FLOORS, default 7, floors 0..NUM_FLOORS-1; FLOOR_W = clog2(NUM_FLOORS).
REQ-003 Parameter: CAP_W, default 3, width of each per-direction boarding count.
REQ-004 Parameter: TURN_DWELL, default 4, cycles a car is held stationary after a reversal (legal range 1..15).
REQ-005 Port: clk  in  1  single system clock; all state updates on rising edge.
REQ-006 Port: rst  in  1  reset, synchronous, active-high.
REQ-007 Port: curr_floor  in  NUM_ELEV*FLOOR_W  packed current floor per car; car i at bits [i*FLOOR_W +: FLOOR_W].
REQ-008 Port: up_req, down_req  in  NUM_FLOORS each  hall-call bitmaps; bit f = pending call at floor f.
REQ-009 Port: boarding  in  NUM_ELEV*2*CAP_W  per car {up_count, down_count} of riders on board.
REQ-010 Port: step  in  NUM_ELEV  one-cycle pulse: car i has arrived at curr_floor and requests a decision.
REQ-011 Port: dir  out  NUM_ELEV  registered direction, 1 = up, 0 = down.
REQ-012 Port: moving  out  NUM_ELEV  registered, 1 = car i in UP or DOWN state.
REQ-013 Port: turn  out  NUM_ELEV  registered one-cycle pulse on each reversal of car i.
REQ-014 Port: floor_err  out  NUM_ELEV  sticky flag, curr_floor >= NUM_FLOORS seen on a step.

Function
REQ-015 Each car SHALL run an independent FSM with states IDLE, UP, DOWN, DWELL.
REQ-016 Per car: any = |(up_req|down_req); above = any call at floor > curr_floor; below = any call at floor < curr_floor; empty = both boarding counts zero.
REQ-017 IDLE: on step with above=1 go UP; else below=1 go DOWN; both set: even car index UP, odd DOWN; neither: stay IDLE.
REQ-018 UP: on step, if !empty or above, stay UP; else if below, enter DWELL with dir<=0 and pulse turn; else go IDLE.
REQ-019 DOWN: mirror of REQ-018 with above/below swapped and dir<=1 on reversal.
REQ-020 DWELL: load counter with TURN_DWELL on entry, decrement each cycle, ignore step; at counter==1 go to UP if dir=1 else DOWN.
REQ-021 Decisions SHALL use inputs sampled in the step cycle; dir, moving, turn update exactly one cycle after step (latency 1).
REQ-022 Car at floor NUM_FLOORS-1 in UP SHALL compute above=0; car at floor 0 in DOWN SHALL compute below=0 (no wrap-around).
REQ-023 Step with curr_floor >= NUM_FLOORS: set floor_err, hold state, dir, and no turn pulse.
REQ-024 step asserted outside a decision state (DWELL) SHALL be dropped, not queued.
REQ-025 turn SHALL be high for exactly one cycle per reversal; IDLE-to-moving transitions never pulse turn.
REQ-026 Calls at curr_floor SHALL not count as above or below.

Reset
REQ-027 On rst: all FSMs IDLE, dir = even car 1 / odd car 0, moving=0, turn=0, floor_err=0, dwell counters 0.
REQ-028 rst SHALL override any concurrent step, including mid-DWELL.

Structure
REQ-029 A shared package SHALL hold the FSM state enum and the direction constants (UP=1, DOWN=0).
REQ-030 One sub-module elevator_car_fsm SHALL implement a single car, instantiated NUM_ELEV times by generate; above/below masking lives in the top.

Verification
REQ-031 Reset, then car0 floor 2, up_req=7'b0100000, step -> next cycle car0 state UP, moving=1, dir=1, turn=0.
REQ-032 Car0 UP at floor 5, empty, no calls above, down_req bit 1 set, step -> turn pulse 1 cycle, dir=0, moving=0 for 4 cycles, then DOWN.
REQ-033 Car1 UP at floor 6 (top), boarding nonzero, step -> stays UP, no turn; same with empty and no calls -> IDLE.
REQ-034 Both cars IDLE at floor 3, calls at floors 5 and 1, simultaneous step -> car0 UP, car1 DOWN in same cycle.
REQ-035 curr_floor=7 with NUM_FLOORS=7, step -> floor_err=1 persists, state unchanged; rst during DWELL -> IDLE next cycle.

Source files
------------

// File: rtl/elevator_dir_ctrl_pkg.sv
// Shared types and constants for the elevator direction controller.
package elevator_dir_ctrl_pkg;

  // Per-car controller state.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_UP    = 2'd1,
    ST_DOWN  = 2'd2,
    ST_DWELL = 2'd3
  } car_state_t;

  // Encoding of the dir output.
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Width of the reversal dwell counter (holds TURN_DWELL up to 15).
  localparam int DWELL_W = 4;

endpackage

// File: rtl/elevator_car_fsm.sv
// Direction FSM for a single elevator car. The top level supplies the
// already-masked above/below/empty summaries and a floor-range flag.
module elevator_car_fsm
  import elevator_dir_ctrl_pkg::*;
#(
  parameter int CAR_IDX    = 0,
  parameter int TURN_DWELL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic step,
  input  logic above,
  input  logic below,
  input  logic empty,
  input  logic floor_ok,
  output logic dir,
  output logic moving,
  output logic turn,
  output logic floor_err
);

  // Even cars idle pointing up, odd cars pointing down; also breaks ties in IDLE.
  localparam logic RST_DIR = (CAR_IDX % 2 == 0) ? DIR_UP : DIR_DOWN;
  localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(TURN_DWELL);
  localparam logic [DWELL_W-1:0] DWELL_ONE  = DWELL_W'(1);

  car_state_t         state, state_nxt;
  logic [DWELL_W-1:0] cnt, cnt_nxt;
  logic               dir_nxt, moving_nxt, turn_nxt, ferr_nxt;
  logic               decide;

  // A step only drives a decision when the reported floor is in range.
  assign decide = step & floor_ok;

  // Next-state, dwell counter and registered-output values.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned; otherwise synthesis infers latches.
    state_nxt = state;
    cnt_nxt   = cnt;
    dir_nxt   = dir;
    turn_nxt  = 1'b0;
    ferr_nxt  = floor_err | (step & ~floor_ok);

    unique case (state)
      ST_IDLE: begin
        if (decide) begin
          if (above && (!below || RST_DIR == DIR_UP)) begin
            state_nxt = ST_UP;
            dir_nxt   = DIR_UP;
          end else if (below) begin
            state_nxt = ST_DOWN;
            dir_nxt   = DIR_DOWN;
          end
        end
      end

      ST_UP: begin
        if (decide) begin
          if (!empty || above) begin
            state_nxt = ST_UP;
          end else if (below) begin
            state_nxt = ST_DWELL;
            dir_nxt   = DIR_DOWN;
            turn_nxt  = 1'b1;
            cnt_nxt   = DWELL_LOAD;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end

      ST_DOWN: begin
        if (decide) begin
          if (!empty || below) begin
            state_nxt = ST_DOWN;
          end else if (above) begin
            state_nxt = ST_DWELL;
            dir_nxt   = DIR_UP;
            turn_nxt  = 1'b1;
            cnt_nxt   = DWELL_LOAD;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end

      ST_DWELL: begin
        // Steps are dropped here; the car leaves when the count reaches one.
        if (cnt <= DWELL_ONE) begin
          state_nxt = (dir == DIR_UP) ? ST_UP : ST_DOWN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - DWELL_ONE;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase

    moving_nxt = (state_nxt == ST_UP) || (state_nxt == ST_DOWN);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the
    // pre-edge values, independent of statement order.
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      dir       <= RST_DIR;
      moving    <= 1'b0;
      turn      <= 1'b0;
      floor_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      dir       <= dir_nxt;
      moving    <= moving_nxt;
      turn      <= turn_nxt;
      floor_err <= ferr_nxt;
    end
  end

endmodule

// File: rtl/elevator_dir_ctrl.sv
// Multi-car elevator direction controller: derives per-car call summaries
// from the shared hall-call bitmaps and runs one direction FSM per car.
module elevator_dir_ctrl
  import elevator_dir_ctrl_pkg::*;
#(
  parameter  int NUM_ELEV   = 2,
  parameter  int NUM_FLOORS = 7,
  parameter  int CAP_W      = 3,
  parameter  int TURN_DWELL = 4,
  localparam int FLOOR_W    = $clog2(NUM_FLOORS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_ELEV*FLOOR_W-1:0]   curr_floor,
  input  logic [NUM_FLOORS-1:0]         up_req,
  input  logic [NUM_FLOORS-1:0]         down_req,
  input  logic [NUM_ELEV*2*CAP_W-1:0]   boarding,
  input  logic [NUM_ELEV-1:0]           step,
  output logic [NUM_ELEV-1:0]           dir,
  output logic [NUM_ELEV-1:0]           moving,
  output logic [NUM_ELEV-1:0]           turn,
  output logic [NUM_ELEV-1:0]           floor_err
);

  logic [NUM_FLOORS-1:0] calls;

  // Hall calls in either direction attract a car.
  assign calls = up_req | down_req;

  for (genvar i = 0; i < NUM_ELEV; i++) begin : g_car
    logic [FLOOR_W-1:0]  cf;
    logic [2*CAP_W-1:0]  brd;
    logic                above, below, empty, floor_ok;

    assign cf       = curr_floor[i*FLOOR_W +: FLOOR_W];
    assign brd      = boarding[i*2*CAP_W +: 2*CAP_W];
    assign empty    = (brd == '0);
    assign floor_ok = (int'(cf) < NUM_FLOORS);

    // Strictly-above / strictly-below call summary; a call at the car's own
    // floor counts for neither, and the floor range provides the end stops.
    always_comb begin
      above = 1'b0;
      below = 1'b0;
      for (int f = 0; f < NUM_FLOORS; f++) begin
        if (calls[f] && (f > int'(cf))) above = 1'b1;
        if (calls[f] && (f < int'(cf))) below = 1'b1;
      end
    end

    elevator_car_fsm #(
      .CAR_IDX    (i),
      .TURN_DWELL (TURN_DWELL)
    ) u_car (
      .clk       (clk),
      .rst       (rst),
      .step      (step[i]),
      .above     (above),
      .below     (below),
      .empty     (empty),
      .floor_ok  (floor_ok),
      .dir       (dir[i]),
      .moving    (moving[i]),
      .turn      (turn[i]),
      .floor_err (floor_err[i])
    );
  end

endmodule

// File: tb/tb_elevator_dir_ctrl.sv
// Self-checking bench for elevator_dir_ctrl (2 cars, 7 floors, dwell 4).
module tb_elevator_dir_ctrl;

  localparam int NUM_ELEV   = 2;
  localparam int NUM_FLOORS = 7;
  localparam int CAP_W      = 3;
  localparam int TURN_DWELL = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  curr_floor = '0;
  logic [6:0]  up_req = '0;
  logic [6:0]  down_req = '0;
  logic [11:0] boarding = '0;
  logic [1:0]  step = '0;
  logic [1:0]  dir, moving, turn, floor_err;

  int checks = 0;
  int errors = 0;

  elevator_dir_ctrl #(
    .NUM_ELEV   (NUM_ELEV),
    .NUM_FLOORS (NUM_FLOORS),
    .CAP_W      (CAP_W),
    .TURN_DWELL (TURN_DWELL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .curr_floor (curr_floor),
    .up_req     (up_req),
    .down_req   (down_req),
    .boarding   (boarding),
    .step       (step),
    .dir        (dir),
    .moving     (moving),
    .turn       (turn),
    .floor_err  (floor_err)
  );

  always #5 clk = ~clk;

  // One clock of stimulus plus the outputs expected one cycle later.
  // Bit 1 of each 2-bit field is car 1, bit 0 is car 0.
  typedef struct {
    string       name;
    logic        rst;
    logic [2:0]  f1, f0;
    logic [6:0]  up, dn;
    logic [11:0] board;
    logic [1:0]  step;
    logic [1:0]  e_dir, e_mov, e_turn, e_ferr;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  function automatic vec_t mk(input string n, input logic r,
                              input logic [2:0] f1, input logic [2:0] f0,
                              input logic [6:0] u, input logic [6:0] d,
                              input logic [11:0] b, input logic [1:0] s,
                              input logic [1:0] ed, input logic [1:0] em,
                              input logic [1:0] et, input logic [1:0] ef);
    vec_t v;
    v.name = n; v.rst = r; v.f1 = f1; v.f0 = f0; v.up = u; v.dn = d;
    v.board = b; v.step = s;
    v.e_dir = ed; v.e_mov = em; v.e_turn = et; v.e_ferr = ef;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Drive one vector, push its expectation, compare after the next edge.
  task automatic run_vec(input vec_t v);
    vec_t e;
    @(negedge clk);
    rst        = v.rst;
    curr_floor = {v.f1, v.f0};
    up_req     = v.up;
    down_req   = v.dn;
    boarding   = v.board;
    step       = v.step;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.name, ".dir"},       32'(dir),       32'(e.e_dir));
    check({e.name, ".moving"},    32'(moving),    32'(e.e_mov));
    check({e.name, ".turn"},      32'(turn),      32'(e.e_turn));
    check({e.name, ".floor_err"}, 32'(floor_err), 32'(e.e_ferr));
  endtask

  initial begin
    int n;
    int turn_hits;

    // name, rst, f1, f0, up_req, down_req, boarding, step -> dir, moving, turn, floor_err
    tbl.push_back(mk("reset_vs_step",      1, 3'd0, 3'd2, 7'b0100000, 7'b0000000, 12'd0, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk("idle_to_up",         0, 3'd0, 3'd2, 7'b0100000, 7'b0000000, 12'd0, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00));
    tbl.push_back(mk("up_hold",            0, 3'd0, 3'd2, 7'b0000000, 7'b0000000, 12'd0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00));
    tbl.push_back(mk("reverse_down",       0, 3'd0, 3'd5, 7'b0000000, 7'b0000010, 12'd0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00));
    tbl.push_back(mk("dwell_a1",           0, 3'd0, 3'd5, 7'b0000000, 7'b0000000, 12'd0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk("dwell_step_drop",    0, 3'd0, 3'd5, 7'b1000000, 7'b0000000, 12'd0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk("dwell_a3",           0, 3'd0, 3'd5, 7'b0000000, 7'b0000000, 12'd0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk("dwell_a_exit",       0, 3'd0, 3'd5, 7'b0000000, 7'b0000000, 12'd0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00));
    tbl.push_back(mk("no_queued_step",     0, 3'd0, 3'd5, 7'b0000000, 7'b0000000, 12'd0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00));
    tbl.push_back(mk("car1_idle_to_up",    0, 3'd2, 3'd5, 7'b1000000, 7'b0000000, 12'd0, 2'b10, 2'b10, 2'b11, 2'b00, 2'b00));
    tbl.push_back(mk("top_loaded_stay",    0, 3'd6, 3'd5, 7'b0000000, 7'b0000000, 12'b010_000_000_000, 2'b10, 2'b10, 2'b11, 2'b00, 2'b00));
    tbl.push_back(mk("top_call_here_idle", 0, 3'd6, 3'd5, 7'b1000000, 7'b0000000, 12'd0, 2'b10, 2'b10, 2'b01, 2'b00, 2'b00));
    tbl.push_back(mk("car0_down_idle",     0, 3'd6, 3'd1, 7'b0000000, 7'b0000000, 12'd0, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk("tie_split",          0, 3'd3, 3'd3, 7'b0100000, 7'b0000010, 12'd0, 2'b11, 2'b01, 2'b11, 2'b00, 2'b00));
    tbl.push_back(mk("bottom_reverse_up",  0, 3'd0, 3'd3, 7'b0010000, 7'b0000000, 12'd0, 2'b10, 2'b11, 2'b01, 2'b10, 2'b00));
    tbl.push_back(mk("dwell_b1",           0, 3'd0, 3'd3, 7'b0000000, 7'b0000000, 12'd0, 2'b00, 2'b11, 2'b01, 2'b00, 2'b00));
    tbl.push_back(mk("floor_err",          0, 3'd0, 3'd7, 7'b1000000, 7'b0000000, 12'd0, 2'b01, 2'b11, 2'b01, 2'b00, 2'b01));
    tbl.push_back(mk("err_sticky",         0, 3'd0, 3'd3, 7'b0000000, 7'b0000000, 12'd0, 2'b00, 2'b11, 2'b01, 2'b00, 2'b01));
    tbl.push_back(mk("dwell_b_exit",       0, 3'd0, 3'd3, 7'b0000000, 7'b0000000, 12'd0, 2'b00, 2'b11, 2'b11, 2'b00, 2'b01));
    tbl.push_back(mk("car0_up_idle",       0, 3'd0, 3'd3, 7'b0000000, 7'b0000000, 12'd0, 2'b01, 2'b11, 2'b10, 2'b00, 2'b01));

    // Hold reset for a couple of cycles before the table starts.
    repeat (2) @(posedge clk);
    foreach (tbl[i]) run_vec(tbl[i]);

    // Reset asserted in the middle of a dwell, together with a step.
    run_vec(mk("pre_rst_up",    0, 3'd0, 3'd3, 7'b0100000, 7'b0000000, 12'd0, 2'b01, 2'b11, 2'b11, 2'b00, 2'b01));
    run_vec(mk("pre_rst_rev",   0, 3'd0, 3'd5, 7'b0000000, 7'b0000010, 12'd0, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01));
    run_vec(mk("rst_mid_dwell", 1, 3'd0, 3'd5, 7'b1000000, 7'b0000000, 12'd0, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00));
    for (int k = 0; k < 6; k++)
      run_vec(mk("post_rst_idle", 0, 3'd0, 3'd5, 7'b0000000, 7'b0000000, 12'd0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00));

    // Dwell length: count cycles from the reversal until car 0 moves again.
    run_vec(mk("len_idle_to_up", 0, 3'd0, 3'd2, 7'b0010000, 7'b0000000, 12'd0, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00));
    run_vec(mk("len_reverse",    0, 3'd0, 3'd4, 7'b0000000, 7'b0000001, 12'd0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00));
    @(negedge clk);
    up_req = '0; down_req = '0; step = '0;
    n = 0;
    turn_hits = 0;
    while (n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (turn[0]) turn_hits++;
      if (moving[0]) break;
    end
    check("dwell_len",    32'(n),         32'(TURN_DWELL));
    check("dwell_no_turn", 32'(turn_hits), 32'd0);
    check("dwell_dir",    32'(dir[0]),    32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
